// File: rtl/riscv_pkg.sv
// Shared definitions for the RV32I control path: opcode constants,
// ALU function encodings, the instruction class and the multi-cycle
// state encoding. Imported by ctrl_decode and multicycle_ctrl.
package riscv_pkg;

   localparam logic [6:0] OPC_LOAD  = 7'b0000011;
   localparam logic [6:0] OPC_OPIMM = 7'b0010011;
   localparam logic [6:0] OPC_STORE = 7'b0100011;
   localparam logic [6:0] OPC_AUIPC = 7'b0010111;
   localparam logic [6:0] OPC_OP    = 7'b0110011;

   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_RTYPE = 2'b10;
   localparam logic [1:0] ALUOP_ITYPE = 2'b11;

   typedef enum logic [2:0] {
      CLS_LOAD,
      CLS_OPIMM,
      CLS_STORE,
      CLS_AUIPC,
      CLS_OP
   } inst_class_t;

   typedef enum logic [2:0] {
      S_FETCH  = 3'd0,
      S_DECODE = 3'd1,
      S_EXEC   = 3'd2,
      S_MEM    = 3'd3,
      S_WB     = 3'd4
   } state_t;

endpackage

// File: rtl/ctrl_decode.sv
// Opcode classifier shared by the single- and multi-cycle controllers.
// Ports:
//   opcode     in  7  InstCode[6:0]
//   inst_class out    decoded class (CLS_OP when illegal)
//   illegal    out 1  opcode is not a supported class
module ctrl_decode
   import riscv_pkg::*;
(
   input  logic [6:0]  opcode,
   output inst_class_t inst_class,
   output logic        illegal
);

   always_comb begin
      inst_class = CLS_OP;
      illegal    = 1'b0;
      case (opcode)
         OPC_LOAD:  inst_class = CLS_LOAD;
         OPC_OPIMM: inst_class = CLS_OPIMM;
         OPC_STORE: inst_class = CLS_STORE;
         OPC_AUIPC: inst_class = CLS_AUIPC;
         OPC_OP:    inst_class = CLS_OP;
         default:   illegal    = 1'b1;
      endcase
   end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle control FSM for the shared RV32I datapath. Sequences
// fetch / decode / execute / memory / write-back over one memory port
// and one ALU, and counts retired instructions.
//
//   state    | meaning
//   ---------+-----------------------------------------------------
//   S_FETCH  | MemRead at PC; on MemAck load IR/OldPC and bump PC
//   S_DECODE | register read; latch class, flag illegal opcodes
//   S_EXEC   | ALU operands/function selected by latched class
//   S_MEM    | load/store at ALUOut, held until MemAck
//   S_WB     | register file write from ALUOut or memory data
//
// Ports:
//   clk, reset (sync, active-high)
//   Opcode, MemAck                       inputs
//   MemRead, MemWrite, IorD, IRWrite, PCWrite, RegWrite, MemtoReg,
//   ALUSrcA, ALUSrcB, ALUOp, Illegal     datapath controls
//   InstCount                            retired-instruction count
module multicycle_ctrl
   import riscv_pkg::*;
#(
   parameter int INST_W = 32,
   parameter int CNT_W  = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [6:0]       Opcode,
   input  logic             MemAck,
   output logic             MemRead,
   output logic             MemWrite,
   output logic             IorD,
   output logic             IRWrite,
   output logic             PCWrite,
   output logic             RegWrite,
   output logic             MemtoReg,
   output logic             ALUSrcA,
   output logic             ALUSrcB,
   output logic [1:0]       ALUOp,
   output logic             Illegal,
   output logic [CNT_W-1:0] InstCount
);

   // The opcode field is carved from the low 7 bits of the instruction.
   if (INST_W < 7) begin : g_inst_w_check
      $error("multicycle_ctrl: INST_W must be at least 7");
   end

   state_t      state, state_nxt;
   inst_class_t cls_q, dec_class;
   logic        dec_illegal;
   logic        retire;

   ctrl_decode u_decode (
      .opcode     (Opcode),
      .inst_class (dec_class),
      .illegal    (dec_illegal)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= S_FETCH;
         cls_q     <= CLS_OP;
         InstCount <= '0;
      end else begin
         state <= state_nxt;
         // Class is captured once; later Opcode changes are ignored.
         if (state == S_DECODE) cls_q <= dec_class;
         if (retire) InstCount <= InstCount + 1'b1;
      end
   end

   always_comb begin
      state_nxt = state;
      retire    = 1'b0;
      MemRead   = 1'b0;
      MemWrite  = 1'b0;
      IorD      = 1'b0;
      IRWrite   = 1'b0;
      PCWrite   = 1'b0;
      RegWrite  = 1'b0;
      MemtoReg  = 1'b0;
      ALUSrcA   = 1'b0;
      ALUSrcB   = 1'b0;
      ALUOp     = ALUOP_ADD;
      Illegal   = 1'b0;

      case (state)
         S_FETCH: begin
            MemRead = 1'b1;
            if (MemAck) begin
               IRWrite   = 1'b1;
               PCWrite   = 1'b1;
               state_nxt = S_DECODE;
            end
         end
         S_DECODE: begin
            if (dec_illegal) begin
               Illegal   = 1'b1;
               state_nxt = S_FETCH;
            end else begin
               state_nxt = S_EXEC;
            end
         end
         S_EXEC: begin
            case (cls_q)
               CLS_LOAD, CLS_STORE: begin
                  ALUSrcB = 1'b1;
                  ALUOp   = ALUOP_ADD;
               end
               CLS_OPIMM: begin
                  ALUSrcB = 1'b1;
                  ALUOp   = ALUOP_ITYPE;
               end
               CLS_AUIPC: begin
                  ALUSrcA = 1'b1;
                  ALUSrcB = 1'b1;
                  ALUOp   = ALUOP_ADD;
               end
               default: begin
                  ALUOp = ALUOP_RTYPE;
               end
            endcase
            state_nxt = (cls_q == CLS_LOAD || cls_q == CLS_STORE) ? S_MEM : S_WB;
         end
         S_MEM: begin
            IorD     = 1'b1;
            MemRead  = (cls_q == CLS_LOAD);
            MemWrite = (cls_q == CLS_STORE);
            if (MemAck) begin
               if (cls_q == CLS_STORE) begin
                  state_nxt = S_FETCH;
                  retire    = 1'b1;
               end else begin
                  state_nxt = S_WB;
               end
            end
         end
         S_WB: begin
            RegWrite  = 1'b1;
            MemtoReg  = (cls_q == CLS_LOAD);
            state_nxt = S_FETCH;
            retire    = 1'b1;
         end
         default: state_nxt = S_FETCH;
      endcase

      // Reset silences every strobe, including the FETCH read.
      if (reset) begin
         retire   = 1'b0;
         MemRead  = 1'b0;
         MemWrite = 1'b0;
         IorD     = 1'b0;
         IRWrite  = 1'b0;
         PCWrite  = 1'b0;
         RegWrite = 1'b0;
         MemtoReg = 1'b0;
         ALUSrcA  = 1'b0;
         ALUSrcB  = 1'b0;
         ALUOp    = ALUOP_ADD;
         Illegal  = 1'b0;
      end
   end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: directed cases plus randomized instruction
// streams with random memory wait states, checked cycle by cycle
// against the instruction timeline model below.
module tb_multicycle_ctrl;

   localparam int CNT_W = 4;

   logic             clk = 1'b0;
   logic             reset;
   logic [6:0]       Opcode;
   logic             MemAck;
   logic             MemRead, MemWrite, IorD, IRWrite, PCWrite;
   logic             RegWrite, MemtoReg, ALUSrcA, ALUSrcB, Illegal;
   logic [1:0]       ALUOp;
   logic [CNT_W-1:0] InstCount;

   int n_chk = 0;
   int n_err = 0;
   int exp_cnt = 0;

   always #5 clk = ~clk;

   multicycle_ctrl #(.INST_W(32), .CNT_W(CNT_W)) dut (
      .clk       (clk),
      .reset     (reset),
      .Opcode    (Opcode),
      .MemAck    (MemAck),
      .MemRead   (MemRead),
      .MemWrite  (MemWrite),
      .IorD      (IorD),
      .IRWrite   (IRWrite),
      .PCWrite   (PCWrite),
      .RegWrite  (RegWrite),
      .MemtoReg  (MemtoReg),
      .ALUSrcA   (ALUSrcA),
      .ALUSrcB   (ALUSrcB),
      .ALUOp     (ALUOp),
      .Illegal   (Illegal),
      .InstCount (InstCount)
   );

   // {MemRead, MemWrite, IorD, IRWrite, PCWrite, RegWrite, MemtoReg,
   //  ALUSrcA, ALUSrcB, ALUOp[1:0], Illegal}
   logic [11:0] ctl;
   assign ctl = {MemRead, MemWrite, IorD, IRWrite, PCWrite, RegWrite,
                 MemtoReg, ALUSrcA, ALUSrcB, ALUOp, Illegal};

   localparam logic [11:0] C_MRD  = 12'h800;
   localparam logic [11:0] C_MWR  = 12'h400;
   localparam logic [11:0] C_IORD = 12'h200;
   localparam logic [11:0] C_IRW  = 12'h100;
   localparam logic [11:0] C_PCW  = 12'h080;
   localparam logic [11:0] C_RGW  = 12'h040;
   localparam logic [11:0] C_M2R  = 12'h020;
   localparam logic [11:0] C_SA   = 12'h010;
   localparam logic [11:0] C_SB   = 12'h008;
   localparam logic [11:0] C_OPR  = 12'h004;   // ALUOp = 10
   localparam logic [11:0] C_OPI  = 12'h006;   // ALUOp = 11
   localparam logic [11:0] C_ILL  = 12'h001;
   localparam logic [11:0] M_STROBE = C_MRD | C_MWR | C_IRW | C_PCW | C_RGW | C_ILL;
   localparam logic [11:0] M_ALU    = C_SA | C_SB | 12'h006;
   localparam logic [11:0] M_ALL    = 12'hFFF;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%h expected 0x%h at %0t", tag, obs, exp, $time);
      end
   endtask

   // One cycle: inputs already driven just after the edge; sample at negedge.
   task automatic cyc(input string tag, input logic [11:0] exp, input logic [11:0] mask);
      @(negedge clk);
      check(tag, {20'd0, ctl & mask}, {20'd0, exp & mask});
      @(posedge clk);
      #1;
   endtask

   function automatic logic [11:0] exec_exp(input logic [6:0] opc);
      case (opc)
         7'h03, 7'h23: return C_SB;
         7'h13:        return C_SB | C_OPI;
         7'h33:        return C_OPR;
         7'h17:        return C_SA | C_SB;
         default:      return 12'h000;
      endcase
   endfunction

   task automatic check_cnt(input string tag);
      check(tag, {28'd0, InstCount}, 32'(exp_cnt));
   endtask

   // Runs one instruction from FETCH: fw / mw are the number of cycles
   // MemAck stays low in FETCH / MEM. rst_mem aborts a load/store in MEM.
   task automatic run_inst(input logic [6:0] opc, input int fw, input int mw, input bit rst_mem);
      bit is_ld, is_st, legal;
      logic [11:0] e;
      is_ld = (opc == 7'h03);
      is_st = (opc == 7'h23);
      legal = is_ld || is_st || opc == 7'h13 || opc == 7'h17 || opc == 7'h33;

      for (int i = 0; i <= fw; i++) begin
         Opcode = 7'($urandom);
         MemAck = (i == fw);
         e = C_MRD;
         if (i == fw) e = e | C_IRW | C_PCW;
         cyc("fetch", e, M_STROBE | C_IORD);
      end

      Opcode = opc;
      MemAck = 1'($urandom);
      cyc("decode", legal ? 12'h000 : C_ILL, M_STROBE);
      if (!legal) begin
         check_cnt("cnt_illegal");
         return;
      end

      Opcode = 7'($urandom);
      MemAck = 1'($urandom);
      cyc("exec", exec_exp(opc), M_STROBE | M_ALU);

      if (is_ld || is_st) begin
         for (int i = 0; i <= mw; i++) begin
            if (rst_mem && i == 1) begin
               reset  = 1'b1;
               MemAck = 1'b0;
               cyc("rst_in_mem", 12'h000, M_ALL);
               reset   = 1'b0;
               exp_cnt = 0;
               check_cnt("cnt_after_rst");
               return;
            end
            MemAck = (i == mw);
            e = C_IORD | (is_ld ? C_MRD : C_MWR);
            cyc("mem", e, M_STROBE | C_IORD);
         end
      end

      if (!is_st) begin
         MemAck = 1'($urandom);
         cyc("wb", C_RGW | (is_ld ? C_M2R : 12'h000), M_STROBE | C_M2R);
      end

      exp_cnt = (exp_cnt + 1) % (1 << CNT_W);
      check_cnt("cnt_retire");
   endtask

   logic [6:0] opc_tbl [5] = '{7'h03, 7'h13, 7'h23, 7'h17, 7'h33};

   initial begin
      logic [6:0] opc;
      int k, fw, mw;
      bit rm;
      reset  = 1'b1;
      MemAck = 1'b0;
      Opcode = 7'h00;
      @(posedge clk);
      #1;
      MemAck = 1'b1;
      cyc("reset_outs", 12'h000, M_ALL);
      cyc("reset_outs", 12'h000, M_ALL);
      exp_cnt = 0;
      check_cnt("cnt_reset");
      reset  = 1'b0;

      run_inst(7'h13, 0, 0, 1'b0);        // ADDI
      run_inst(7'h03, 2, 2, 1'b0);        // LW, slow memory
      run_inst(7'h23, 0, 0, 1'b0);        // SW
      run_inst(7'h7F, 0, 0, 1'b0);        // illegal
      run_inst(7'h03, 1, 3, 1'b1);        // reset while MEM waits
      for (int i = 0; i < 16; i++) run_inst(7'h17, 0, 0, 1'b0);   // AUIPC wrap
      check_cnt("cnt_wrapped");

      for (int n = 0; n < 120; n++) begin
         k  = $urandom_range(0, 5);
         fw = $urandom_range(0, 3);
         mw = $urandom_range(0, 3);
         rm = ($urandom_range(0, 15) == 0);
         if (k == 5) opc = 7'($urandom) | 7'h40;
         else        opc = opc_tbl[k];
         if (rm && mw < 1) mw = 2;
         run_inst(opc, fw, mw, rm);
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
